instr_fetch_decode: RTL

Instruction-register and pre-decode stage directly upstream of the immediate sign extender.
- Fetches one 32-bit instruction from instruction memory over a request/grant/response handshake and latches it.
- Classifies the opcode into the 3-bit immediate-format code the extender consumes.
- Presents instruction and format to the control unit with a valid/ready handshake.

---
 rtl/instr_fetch_decode.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_decode.sv
// Instruction fetch register and immediate-format pre-decode feeding the sign extender.
// Optional build macro IFD_ILLEGAL_CHECK_EN flags opcodes outside the recognised set.
module instr_fetch_decode #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_en,
    output logic        fetch_req,
    input  logic        fetch_gnt,
    input  logic        fetch_rvalid,
    input  logic [31:0] fetch_rdata,
    input  logic        err_clr,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] Instr31_0,
    output logic [2:0]  InstrType,
    output logic        fetch_err,
    output logic        illegal
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, ERR} state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [6:0]       opcode;
    logic [2:0]       fmt;
    logic             unknown;

    assign opcode = fetch_rdata[6:0];

    always_comb begin
        fmt = 3'b111;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b1110011:             fmt = 3'b000;
            7'b0100011:                         fmt = 3'b001;
            7'b1100011:                         fmt = 3'b010;
            7'b1101111:                         fmt = 3'b011;
            7'b0110111, 7'b0010111:             fmt = 3'b100;
            default:                            fmt = 3'b111;
        endcase
    end

    // R-type opcodes are legal but carry no immediate, so they also decode to 111
    assign unknown = (fmt == 3'b111) && (opcode != 7'b0110011) && (opcode != 7'b0111011);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            fetch_req <= 1'b0;
            dec_valid <= 1'b0;
            fetch_err <= 1'b0;
            illegal   <= 1'b0;
            Instr31_0 <= 32'h0;
            InstrType <= 3'b111;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        state     <= REQ;
                        fetch_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (fetch_gnt) begin
                        state     <= WAIT;
                        fetch_req <= 1'b0;
                        timer     <= '0;
                    end
                end
                WAIT: begin
                    if (fetch_rvalid) begin
                        state     <= VALID;
                        dec_valid <= 1'b1;
                        Instr31_0 <= fetch_rdata;
                        InstrType <= fmt;
`ifdef IFD_ILLEGAL_CHECK_EN
                        illegal   <= unknown;
`else
                        illegal   <= 1'b0;
`endif
                    end else if (timer == TIMER_LAST) begin
                        state     <= ERR;
                        fetch_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                VALID: begin
                    if (dec_ready) begin
                        dec_valid <= 1'b0;
                        if (fetch_en) begin
                            state     <= REQ;
                            fetch_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                ERR: begin
                    if (err_clr) begin
                        state     <= IDLE;
                        fetch_err <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    fetch_req <= 1'b0;
                    dec_valid <= 1'b0;
                end
            endcase
        end
    end

`ifndef IFD_ILLEGAL_CHECK_EN
    logic unused_unknown;
    assign unused_unknown = unknown;
`endif

endmodule
